axi_rdata_xbar: RTL and testbench
=================================

Name: axi_rdata_xbar

Overview:
Parametrised read-data (R) channel crossbar for the AXI interconnect, successor to the fixed 3-slave/2-master fixed-priority R mux. Routes R beats from NS slaves (default slave included as the highest index) to NM masters, using the master index carried in the upper RID bits. Arbitration among slaves is round-robin. A grant is locked for a whole burst until the RLast beat is handshaken. Output passes through a one-entry register slice, so the slave-to-master path is fully registered.

Parameters:
NS, 3, number of slave ports (last index = default slave)
NM, 2, number of master ports
ID_W, 4, master-side RID width (AXI_ID_BITS)
IDS_W, 8, slave-side RID width (AXI_IDS_BITS); bits [IDS_W-1:ID_W] = binary master index
DATA_W, 32, RDATA width (AXI_DATA_BITS)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
S_RID  in  NS x IDS_W  slave RID
S_RData  in  NS x DATA_W  slave RDATA
S_RResp  in  NS x 2  slave RRESP
S_RLast  in  NS  slave RLAST
S_RValid  in  NS  slave RVALID
S_RReady  out  NS  slave RREADY
M_RID  out  NM x ID_W  master RID (lower ID_W bits of slave RID)
M_RData  out  NM x DATA_W  master RDATA
M_RResp  out  NM x 2  master RRESP
M_RLast  out  NM  master RLAST
M_RValid  out  NM  master RVALID
M_RReady  in  NM  master RREADY
route_err  out  1  one-cycle pulse: beat addressed to master index >= NM was dropped

Behaviour:
- Reset (rst=1 at posedge clk): FSM=IDLE, rr pointer=0, slice empty, all M_RValid=0, M_RID/RData/RResp/RLast=0, S_RReady=0, route_err=0. Reset mid-burst abandons the burst; no beat is output after reset.
- Arbiter FSM:
  - IDLE: among S_RValid, grant the first requester at or after rr pointer (wrapping modulo NS). The grant takes effect in the same cycle, so a beat can be accepted in the grant cycle.
  - If the accepted beat has RLast=1, stay IDLE and set rr = grant+1 mod NS. Otherwise go to BURST holding the grant.
  - BURST: only the granted slave is served. Other slaves' S_RReady=0 regardless of their RValid. On handshake of a beat with RLast=1: go to IDLE, rr = grant+1 mod NS.
- Destination: dest = S_RID[grant][IDS_W-1:ID_W], recomputed per beat (not latched). All beats of one burst carry the same ID.
- Register slice (full throughput):
  - S_RReady[grant] = slice_empty | M_RReady[slice_dest]. All non-granted S_RReady=0 (combinational from grant, slice state, M_RReady; no S_RValid->S_RReady loop through the same slave).
  - On slave handshake: load id/data/resp/last/dest into the slice, slice full.
  - On master handshake without a new load: slice empty.
  - Simultaneous unload and load: slice stays full with the new beat.
  - Latency: slave handshake at cycle N -> M_RValid visible at cycle N+1.
  - Only M_RValid[slice_dest]=1. Data/ID/Resp/Last fields are broadcast to all masters from the slice.
  - Outputs are held stable while M_RValid=1 and M_RReady=0 (AXI rule).
- Bad destination (dest >= NM): the beat is accepted (S_RReady follows slice availability), not loaded into the slice, and route_err pulses for 1 cycle. Burst lock and RLast tracking still apply, so a bad burst is drained entirely.
- Simultaneous events: a new grant in IDLE while the slice is full and draining is allowed (pass-through). An RLast handshake and a new request in the same cycle: the new grant occurs next cycle at the earliest (FSM registered).
- No combinational path from M_RReady to M_RValid.

Decomposition:
- Shared package axi_pkg (existing): AXI_ID_BITS, AXI_IDS_BITS, AXI_DATA_BITS, RESP enum (OKAY/EXOKAY/SLVERR/DECERR), rdata_beat_t struct {id, data, resp, last}.
- One natural sub-module: rr_arbiter (parameter N; inputs req, lock, advance; outputs one-hot gnt and index). Register slice kept inline.

Test Plan:
- Single beat: S1 RID=8'h13, RData=32'hDEAD_BEEF, RLast=1, M1 ready -> cycle+1: M1_RValid=1, M1_RID=4'h3, RData=DEAD_BEEF; M0_RValid=0.
- Burst lock: S0 4-beat burst to M0 with S1 requesting throughout -> S1_RReady=0 until S0's RLast handshake; S1's beats follow immediately after.
- Round-robin: S0, S1, DS all issue continuous single-beat responses to M0 -> grant order S0, S1, DS, S0, … (each exactly 1 of every 3 beats).
- Backpressure: M0_RReady low for 5 cycles during a burst -> slice holds beat 2 stable, S0_RReady=0, no beat lost or duplicated; 4 beats in order after release.
- Bad route: DS RID=8'h25 (NM=2), 2-beat burst -> both beats accepted, route_err pulses twice, no M_RValid; next request from S0 served normally.
- Reset mid-burst: rst asserted after beat 2 of 4 -> next cycle all M_RValid=0, S_RReady=0, rr=0; a fresh burst after reset routes correctly.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg
// Shared AXI definitions for the interconnect.
//   AXI_ID_BITS / AXI_IDS_BITS / AXI_DATA_BITS : default ID and data widths
//   resp_e       : RRESP encoding
//   rdata_beat_t : one R-channel beat as seen by a master
//   arb_state_e  : state of the R-channel round-robin arbiter
//   idx_bits()   : width of an index selecting one of n items (minimum 1)
package axi_pkg;

  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_DATA_BITS = 32;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef struct packed {
    logic [AXI_ID_BITS-1:0]   id;
    logic [AXI_DATA_BITS-1:0] data;
    resp_e                    resp;
    logic                     last;
  } rdata_beat_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter with burst locking.
//   clk, rst  : clock, synchronous active-high reset
//   req       : one request per port
//   lock      : the granted port completed a non-final beat; hold the grant
//   advance   : the granted port completed its final beat; release and rotate
//   gnt       : one-hot grant (all zero when idle with no requests)
//   gnt_idx   : binary index of the granted port
// In IDLE the grant is combinational from req so a beat can be taken in the
// grant cycle; in BURST the held index is granted regardless of req.
module rr_arbiter
  import axi_pkg::*;
#(
  parameter int N = 3,
  localparam int IW = idx_bits(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          lock,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] hold_q, hold_d;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand_idx;
  logic [IW-1:0] next_idx;
  logic          pick_found;
  logic          active;
  int            cand;

  // Search for the first requester starting at the rr pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IW'(cand);
      if (!pick_found && req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    active  = (state_q == ARB_BURST) || pick_found;
    gnt_idx = (state_q == ARB_BURST) ? hold_q : pick_idx;
    gnt     = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = active && (gnt_idx == IW'(i));
    end
    next_idx = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    case (state_q)
      ARB_IDLE: begin
        if (advance) begin
          rr_d = next_idx;
        end else if (lock) begin
          state_d = ARB_BURST;
          hold_d  = gnt_idx;
        end
      end
      ARB_BURST: begin
        if (advance) begin
          state_d = ARB_IDLE;
          rr_d    = next_idx;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      rr_q    <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/axi_rdata_xbar.sv
// axi_rdata_xbar
// AXI read-data channel crossbar: NS slaves (last = default slave) to NM
// masters. The destination master is the binary index in S_RID[IDS_W-1:ID_W].
//   clk, rst               : clock, synchronous active-high reset
//   S_RID/RData/RResp/RLast/RValid, S_RReady : slave-side R channels
//   M_RID/RData/RResp/RLast/RValid, M_RReady : master-side R channels
//   route_err              : one-cycle pulse per dropped beat whose destination
//                            index is not a valid master
// Slaves are arbitrated round-robin with the grant locked for a whole burst.
// Beats pass through a one-entry register slice, so outputs are registered.
module axi_rdata_xbar
  import axi_pkg::*;
#(
  parameter int NS     = 3,
  parameter int NM     = 2,
  parameter int ID_W   = AXI_ID_BITS,
  parameter int IDS_W  = AXI_IDS_BITS,
  parameter int DATA_W = AXI_DATA_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NS-1:0][IDS_W-1:0]    S_RID,
  input  logic [NS-1:0][DATA_W-1:0]   S_RData,
  input  logic [NS-1:0][1:0]          S_RResp,
  input  logic [NS-1:0]               S_RLast,
  input  logic [NS-1:0]               S_RValid,
  output logic [NS-1:0]               S_RReady,
  output logic [NM-1:0][ID_W-1:0]     M_RID,
  output logic [NM-1:0][DATA_W-1:0]   M_RData,
  output logic [NM-1:0][1:0]          M_RResp,
  output logic [NM-1:0]               M_RLast,
  output logic [NM-1:0]               M_RValid,
  input  logic [NM-1:0]               M_RReady,
  output logic                        route_err
);

  localparam int SW = idx_bits(NS);
  localparam int MW = idx_bits(NM);
  localparam int DW = IDS_W - ID_W;

  logic [NS-1:0]     gnt;
  logic [SW-1:0]     gnt_idx;

  logic [IDS_W-1:0]  sel_id;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        sel_resp;
  logic              sel_last;
  logic              sel_valid;
  logic [DW-1:0]     dest;
  logic              bad_dest;

  logic              slice_valid_q, slice_valid_d;
  logic [MW-1:0]     slice_dest_q,  slice_dest_d;
  logic [ID_W-1:0]   slice_id_q,    slice_id_d;
  logic [DATA_W-1:0] slice_data_q,  slice_data_d;
  logic [1:0]        slice_resp_q,  slice_resp_d;
  logic              slice_last_q,  slice_last_d;
  logic              route_err_q,   route_err_d;

  logic              m_ready_sel;
  logic              slice_free;
  logic              s_hs;
  logic              load;

  rr_arbiter #(.N(NS)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (S_RValid),
    .lock    (s_hs & ~sel_last),
    .advance (s_hs & sel_last),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Mux the granted slave's beat; destination is taken fresh from every beat.
  always_comb begin
    sel_id   = '0;
    sel_data = '0;
    sel_resp = '0;
    sel_last = 1'b0;
    for (int s = 0; s < NS; s++) begin
      if (gnt_idx == SW'(s)) begin
        sel_id   = S_RID[s];
        sel_data = S_RData[s];
        sel_resp = S_RResp[s];
        sel_last = S_RLast[s];
      end
    end
    sel_valid = |(gnt & S_RValid);
    dest      = sel_id[IDS_W-1:ID_W];
    bad_dest  = (int'(dest) >= NM);
  end

  // The slice can take a beat when empty or when its current beat leaves this
  // cycle; that depends only on slice state and M_RReady, never on M_RValid.
  always_comb begin
    m_ready_sel = 1'b0;
    for (int m = 0; m < NM; m++) begin
      if (slice_dest_q == MW'(m)) m_ready_sel = M_RReady[m];
    end
    slice_free = ~slice_valid_q | m_ready_sel;
    for (int s = 0; s < NS; s++) begin
      S_RReady[s] = ~rst & gnt[s] & slice_free;
    end
    s_hs = ~rst & sel_valid & slice_free;
    load = s_hs & ~bad_dest;
  end

  // Misrouted beats are still consumed (so the burst drains) but never loaded.
  always_comb begin
    slice_valid_d = slice_valid_q;
    slice_dest_d  = slice_dest_q;
    slice_id_d    = slice_id_q;
    slice_data_d  = slice_data_q;
    slice_resp_d  = slice_resp_q;
    slice_last_d  = slice_last_q;
    route_err_d   = s_hs & bad_dest;
    if (load) begin
      slice_valid_d = 1'b1;
      slice_dest_d  = dest[MW-1:0];
      slice_id_d    = sel_id[ID_W-1:0];
      slice_data_d  = sel_data;
      slice_resp_d  = sel_resp;
      slice_last_d  = sel_last;
    end else if (slice_valid_q && m_ready_sel) begin
      slice_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slice_valid_q <= 1'b0;
      slice_dest_q  <= '0;
      slice_id_q    <= '0;
      slice_data_q  <= '0;
      slice_resp_q  <= '0;
      slice_last_q  <= 1'b0;
      route_err_q   <= 1'b0;
    end else begin
      slice_valid_q <= slice_valid_d;
      slice_dest_q  <= slice_dest_d;
      slice_id_q    <= slice_id_d;
      slice_data_q  <= slice_data_d;
      slice_resp_q  <= slice_resp_d;
      slice_last_q  <= slice_last_d;
      route_err_q   <= route_err_d;
    end
  end

  // Payload is broadcast; only the addressed master sees RVALID.
  always_comb begin
    for (int m = 0; m < NM; m++) begin
      M_RValid[m] = slice_valid_q && (slice_dest_q == MW'(m));
      M_RID[m]    = slice_id_q;
      M_RData[m]  = slice_data_q;
      M_RResp[m]  = slice_resp_q;
      M_RLast[m]  = slice_last_q;
    end
    route_err = route_err_q;
  end

endmodule

// File: tb/tb_axi_rdata_xbar.sv
// tb_axi_rdata_xbar
// Self-checking bench for axi_rdata_xbar. Slave beats are queued per slave and
// driven by one driver process; a monitor at the falling edge models the
// arbitration rules, pushes expected beats per master and compares every
// master handshake, the next-cycle visibility of each beat, and hold stability.
module tb_axi_rdata_xbar;

  localparam int NS     = 3;
  localparam int NM     = 2;
  localparam int ID_W   = 4;
  localparam int IDS_W  = 8;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic [NS-1:0][IDS_W-1:0]  S_RID;
  logic [NS-1:0][DATA_W-1:0] S_RData;
  logic [NS-1:0][1:0]        S_RResp;
  logic [NS-1:0]             S_RLast;
  logic [NS-1:0]             S_RValid;
  logic [NS-1:0]             S_RReady;
  logic [NM-1:0][ID_W-1:0]   M_RID;
  logic [NM-1:0][DATA_W-1:0] M_RData;
  logic [NM-1:0][1:0]        M_RResp;
  logic [NM-1:0]             M_RLast;
  logic [NM-1:0]             M_RValid;
  logic [NM-1:0]             M_RReady;
  logic                      route_err;

  always #5 clk = ~clk;

  axi_rdata_xbar #(.NS(NS), .NM(NM), .ID_W(ID_W), .IDS_W(IDS_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .S_RID(S_RID), .S_RData(S_RData), .S_RResp(S_RResp), .S_RLast(S_RLast),
    .S_RValid(S_RValid), .S_RReady(S_RReady),
    .M_RID(M_RID), .M_RData(M_RData), .M_RResp(M_RResp), .M_RLast(M_RLast),
    .M_RValid(M_RValid), .M_RReady(M_RReady),
    .route_err(route_err)
  );

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t sq [NS][$];
  beat_t exp_q [NM][$];
  beat_t cur [NS];

  int n_vec = 0;
  int n_err = 0;
  int bad_exp = 0;
  int err_seen = 0;
  int hs_count [NS];
  logic [NS-1:0] slv_hs = '0;
  bit flush_all = 1'b0;
  bit gap_en = 1'b0;
  bit ready_rand = 1'b0;
  logic [NM-1:0] ready_force = '1;

  // Reference model state: round-robin pointer and locked slave (-1 = none).
  int m_rr = 0;
  int m_lock = -1;
  bit pend_valid = 1'b0;
  beat_t pend_beat;
  bit prev_stall [NM];
  logic [38:0] prev_fields [NM];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue one burst of n beats on slave s; data counts up from base.
  task automatic applyStimulus(input int s, input logic [7:0] id, input int n, input logic [31:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.id   = id;
      b.data = base + 32'(i);
      b.resp = 2'($urandom_range(3));
      b.last = (i == n - 1);
      sq[s].push_back(b);
    end
  endtask

  function automatic bit allIdle();
    bit r = (S_RValid == '0) && (M_RValid == '0);
    for (int s = 0; s < NS; s++) if (sq[s].size() != 0) r = 1'b0;
    for (int m = 0; m < NM; m++) if (exp_q[m].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic waitDrain(input string name, input int limit);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk); #1;
      done = allIdle();
    end
    checkOutput(name, 64'(done), 64'd1);
    repeat (3) @(posedge clk);
  endtask

  task automatic waitSlaveBeats(input int s, input int target, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk); #2;
      ok = (hs_count[s] >= target);
    end
    checkOutput(name, 64'(ok), 64'd1);
  endtask

  // Slave driver: holds each beat until its handshake, then presents the next.
  initial begin
    S_RID = '0; S_RData = '0; S_RResp = '0; S_RLast = '0; S_RValid = '0;
    forever begin
      @(posedge clk); #1;
      for (int s = 0; s < NS; s++) begin
        if (flush_all) begin
          sq[s].delete();
          S_RValid[s] = 1'b0;
        end else begin
          if (slv_hs[s]) S_RValid[s] = 1'b0;
          if (!S_RValid[s] && sq[s].size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
            cur[s] = sq[s].pop_front();
            S_RID[s]   = cur[s].id;
            S_RData[s] = cur[s].data;
            S_RResp[s] = cur[s].resp;
            S_RLast[s] = cur[s].last;
            S_RValid[s] = 1'b1;
          end
        end
      end
    end
  end

  // Master ready driver.
  initial begin
    M_RReady = '1;
    forever begin
      @(posedge clk); #1;
      M_RReady = ready_rand ? NM'($urandom) : ready_force;
    end
  end

  // Monitor / scoreboard.
  initial begin
    int s_hit;
    int exp_s;
    int d;
    logic [NM-1:0] ov;
    beat_t e;
    for (int s = 0; s < NS; s++) hs_count[s] = 0;
    for (int m = 0; m < NM; m++) begin prev_stall[m] = 1'b0; prev_fields[m] = '0; end
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int m = 0; m < NM; m++) begin exp_q[m].delete(); prev_stall[m] = 1'b0; end
        m_rr = 0; m_lock = -1; pend_valid = 1'b0; slv_hs = '0;
      end else begin
        if (pend_valid) begin
          d = int'(pend_beat.id[7:4]);
          ov = '0; ov[d] = 1'b1;
          checkOutput("next_cycle_out", {M_RValid, M_RID[d], M_RData[d], M_RResp[d], M_RLast[d]},
                      {ov, pend_beat.id[3:0], pend_beat.data, pend_beat.resp, pend_beat.last});
          pend_valid = 1'b0;
        end
        for (int m = 0; m < NM; m++) begin
          if (prev_stall[m]) begin
            checkOutput("hold_valid", 64'(M_RValid[m]), 64'd1);
            checkOutput("hold_fields", {M_RID[m], M_RData[m], M_RResp[m], M_RLast[m]}, prev_fields[m]);
          end
        end
        if (M_RValid != '0) checkOutput("single_m_valid", 64'($countones(M_RValid)), 64'd1);
        for (int m = 0; m < NM; m++) begin
          if (M_RValid[m] && M_RReady[m]) begin
            if (exp_q[m].size() == 0) begin
              checkOutput("unexpected_beat", 64'd1, 64'd0);
            end else begin
              e = exp_q[m].pop_front();
              checkOutput("master_beat", {M_RID[m], M_RData[m], M_RResp[m], M_RLast[m]},
                          {e.id[3:0], e.data, e.resp, e.last});
            end
          end
          prev_stall[m]  = M_RValid[m] && !M_RReady[m];
          prev_fields[m] = {M_RID[m], M_RData[m], M_RResp[m], M_RLast[m]};
        end
        if (m_lock >= 0) begin
          for (int s = 0; s < NS; s++)
            if (s != m_lock) checkOutput("lock_other_ready", 64'(S_RReady[s]), 64'd0);
        end
        slv_hs = S_RValid & S_RReady;
        if (slv_hs != '0) begin
          checkOutput("single_slave_hs", 64'($countones(slv_hs)), 64'd1);
          s_hit = 0;
          for (int s = NS - 1; s >= 0; s--) if (slv_hs[s]) s_hit = s;
          if (m_lock >= 0) exp_s = m_lock;
          else begin
            exp_s = -1;
            for (int k = 0; k < NS; k++)
              if (exp_s < 0 && S_RValid[(m_rr + k) % NS]) exp_s = (m_rr + k) % NS;
          end
          checkOutput("grant_slave", 64'(s_hit), 64'(exp_s));
          e = cur[s_hit];
          hs_count[s_hit]++;
          if (int'(e.id[7:4]) < NM) begin
            exp_q[int'(e.id[7:4])].push_back(e);
            pend_beat = e;
            pend_valid = 1'b1;
          end else begin
            bad_exp++;
          end
          if (e.last) begin m_lock = -1; m_rr = (s_hit + 1) % NS; end
          else m_lock = s_hit;
        end
      end
      if (route_err) err_seen++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0;
    int base;
    int len;
    int dst;
    int sl;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("reset_m_valid", 64'(M_RValid), 64'd0);
    checkOutput("reset_s_ready", 64'(S_RReady), 64'd0);
    checkOutput("reset_route_err", 64'(route_err), 64'd0);
    checkOutput("reset_m_fields", {M_RID, M_RResp, M_RLast}, 64'd0);
    checkOutput("reset_m_data", 64'(M_RData), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    $display("[TB] single beat to M1");
    applyStimulus(1, 8'h13, 1, 32'hDEAD_BEEF);
    waitDrain("drain_single", 100);

    $display("[TB] burst lock");
    applyStimulus(0, 8'h01, 4, 32'h1000_0000);
    applyStimulus(1, 8'h02, 3, 32'h2000_0000);
    waitDrain("drain_lock", 200);

    $display("[TB] round robin");
    for (int k = 0; k < 6; k++)
      for (int s = 0; s < NS; s++) applyStimulus(s, 8'h0A, 1, 32'h3000_0000 + 32'(k * 16 + s));
    waitDrain("drain_rr", 300);

    $display("[TB] backpressure");
    base = hs_count[0];
    applyStimulus(0, 8'h05, 4, 32'h4000_0000);
    waitSlaveBeats(0, base + 2, "bp_wait");
    ready_force = 2'b10;
    repeat (5) @(posedge clk);
    #2;
    checkOutput("bp_slave_count", 64'(hs_count[0] - base), 64'd3);
    ready_force = '1;
    waitDrain("drain_bp", 200);

    $display("[TB] bad route");
    e0 = err_seen;
    applyStimulus(2, 8'h25, 2, 32'h5000_0000);
    waitDrain("drain_bad", 100);
    checkOutput("bad_route_pulses", 64'(err_seen - e0), 64'd2);
    applyStimulus(0, 8'h07, 1, 32'h5100_0000);
    waitDrain("drain_after_bad", 100);

    $display("[TB] reset mid-burst");
    base = hs_count[0];
    applyStimulus(0, 8'h11, 4, 32'h6000_0000);
    waitSlaveBeats(0, base + 2, "rst_wait");
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    checkOutput("midrst_m_valid", 64'(M_RValid), 64'd0);
    checkOutput("midrst_s_ready", 64'(S_RReady), 64'd0);
    flush_all = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    flush_all = 1'b0;
    applyStimulus(1, 8'h02, 1, 32'h7100_0000);
    applyStimulus(0, 8'h12, 3, 32'h7000_0000);
    waitDrain("drain_after_rst", 200);

    $display("[TB] random traffic");
    gap_en = 1'b1;
    ready_rand = 1'b1;
    for (int k = 0; k < 60; k++) begin
      sl  = $urandom_range(NS - 1);
      len = $urandom_range(1, 4);
      dst = $urandom_range(0, 2);
      applyStimulus(sl, {4'(dst), 4'($urandom_range(15))}, len, $urandom);
    end
    waitDrain("drain_random", 5000);
    ready_rand = 1'b0;
    gap_en = 1'b0;
    repeat (4) @(posedge clk);
    checkOutput("route_err_total", 64'(err_seen), 64'(bad_exp));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
